// File: rtl/wbit_alu_2305001_if.sv
// Operand/result bundle between the datapath and the ALU (wbit_alu_2305001).
// master drives operands and op select; slave returns the registered result and flags.
interface wbit_alu_2305001_if #(
    parameter int unsigned W = 5
);
    logic [W-1:0] InA;
    logic [W-1:0] InB;
    logic [2:0]   ALU_Control;
    logic [W-1:0] Result;
    logic [3:0]   NZCV;

    modport master (
        output InA, InB, ALU_Control,
        input  Result, NZCV
    );

    modport slave (
        input  InA, InB, ALU_Control,
        output Result, NZCV
    );
endinterface

// File: rtl/wbit_alu_2305001.sv
// W-bit registered integer ALU with ARM-style NZCV flags, one-cycle latency.
// Optional build macro WBIT_ALU_FLAG_HOLD_EN: logic ops keep the previously
// registered C and V instead of clearing them (N and Z always update).
module wbit_alu_2305001 #(
    parameter int unsigned W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wbit_alu_2305001_if.slave     bus
);

    localparam int unsigned SW = W + 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_RSB  = 3'b010;
    localparam logic [2:0] OP_BIC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ORR  = 3'b101;
    localparam logic [2:0] OP_EOR  = 3'b110;

    logic [W-1:0]  result_q;
    logic [3:0]    nzcv_q;

    logic [W-1:0]  op_x;
    logic [W-1:0]  op_y;
    logic          cin;
    logic [SW-1:0] sum;
    logic [W-1:0]  result_nxt;
    logic          c_nxt;
    logic          v_nxt;
    logic          n_nxt;
    logic          z_nxt;

    // Shared adder: subtracts are x + ~y + 1 with operands ordered per op
    always_comb begin
        op_x = bus.InA;
        op_y = bus.InB;
        cin  = 1'b0;
        unique case (bus.ALU_Control)
            OP_SUB: begin
                op_x = bus.InA;
                op_y = ~bus.InB;
                cin  = 1'b1;
            end
            OP_RSB: begin
                op_x = bus.InB;
                op_y = ~bus.InA;
                cin  = 1'b1;
            end
            default: ;
        endcase
        sum = SW'(op_x) + SW'(op_y) + SW'(cin);
    end

    // Result mux and flag generation
    always_comb begin
`ifdef WBIT_ALU_FLAG_HOLD_EN
        c_nxt = nzcv_q[1];
        v_nxt = nzcv_q[0];
`else
        c_nxt = 1'b0;
        v_nxt = 1'b0;
`endif
        result_nxt = ~(bus.InA ^ bus.InB);
        unique case (bus.ALU_Control)
            OP_ADD, OP_SUB, OP_RSB: begin
                result_nxt = sum[W-1:0];
                c_nxt      = sum[W];
                // Inverted subtrahend makes sub overflow the same rule as add
                v_nxt      = (op_x[W-1] == op_y[W-1]) && (sum[W-1] != op_x[W-1]);
            end
            OP_BIC: result_nxt = bus.InA & ~bus.InB;
            OP_AND: result_nxt = bus.InA & bus.InB;
            OP_ORR: result_nxt = bus.InA | bus.InB;
            OP_EOR: result_nxt = bus.InA ^ bus.InB;
            default: ;
        endcase
        n_nxt = result_nxt[W-1];
        z_nxt = (result_nxt == '0);
    end

    // Output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            nzcv_q   <= 4'b0000;
        end else begin
            result_q <= result_nxt;
            nzcv_q   <= {n_nxt, z_nxt, c_nxt, v_nxt};
        end
    end

    assign bus.Result = result_q;
    assign bus.NZCV   = nzcv_q;

endmodule

// File: tb/tb_wbit_alu_2305001.sv
// Self-checking bench for wbit_alu_2305001 (W=5): directed table, reset and
// flag-hold sequences, then random vectors against an arithmetic reference model.
module tb_wbit_alu_2305001;

    localparam int unsigned W = 5;
    localparam int M    = 1 << W;
    localparam int HALF = M / 2;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // Reference model's registered C/V (needed for flag-hold builds)
    logic mc;
    logic mv;

    wbit_alu_2305001_if #(.W(W)) bus ();

    wbit_alu_2305001 #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_r;
        logic [3:0]   exp_f;
    } vec_t;

    function automatic int to_signed(input int u);
        return (u >= HALF) ? u - M : u;
    endfunction

    function automatic logic ovf(input int s);
        return (s >= HALF) || (s < -HALF);
    endfunction

    // Returns {result, N, Z, C, V} from plain integer arithmetic
    function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic pc, input logic pv);
        int ai = int'(a);
        int bi = int'(b);
        int r;
        logic c;
        logic v;
        logic [W-1:0] rv;
`ifdef WBIT_ALU_FLAG_HOLD_EN
        c = pc;
        v = pv;
`else
        c = 1'b0;
        v = 1'b0;
`endif
        case (op)
            3'd0: begin
                r = (ai + bi) % M;
                c = (ai + bi) >= M;
                v = ovf(to_signed(ai) + to_signed(bi));
            end
            3'd1: begin
                r = (ai - bi + M) % M;
                c = ai >= bi;
                v = ovf(to_signed(ai) - to_signed(bi));
            end
            3'd2: begin
                r = (bi - ai + M) % M;
                c = bi >= ai;
                v = ovf(to_signed(bi) - to_signed(ai));
            end
            3'd3: r = int'(a & ~b);
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = int'(~(a ^ b));
        endcase
        rv = W'(r);
        return {rv, rv[W-1], (r == 0), c, v};
    endfunction

    task automatic check(input string name, input logic [W-1:0] got_r, input logic [3:0] got_f,
                         input logic [W-1:0] exp_r, input logic [3:0] exp_f, input logic [3:0] mask);
        vectors++;
        if (got_r !== exp_r || (got_f & mask) !== (exp_f & mask)) begin
            miscompares++;
            $display("FAIL %s: got Result=%b NZCV=%b, expected Result=%b NZCV=%b (mask %b)",
                     name, got_r, got_f, exp_r, exp_f, mask);
        end
    endtask

    // Drive one op, clock it, sample #1 after the edge and compare
    task automatic apply(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_r,
                         input logic [3:0] exp_f, input logic [3:0] mask);
        logic [W+3:0] m;
        bus.ALU_Control = op;
        bus.InA = a;
        bus.InB = b;
        m  = model(op, a, b, mc, mv);
        mc = m[1];
        mv = m[0];
        @(posedge clk);
        #1;
        check(name, bus.Result, bus.NZCV, exp_r, exp_f, mask);
    endtask

    vec_t tbl[$];
    logic [3:0] tmask;
    logic [W+3:0] mexp;
    logic [2:0] rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        vectors     = 0;
        miscompares = 0;
        mc = 1'b0;
        mv = 1'b0;

        tbl.push_back('{"add_wrap",   3'b000, 5'b11111, 5'b00001, 5'b00000, 4'b0110});
        tbl.push_back('{"add_ovf",    3'b000, 5'b01111, 5'b00001, 5'b10000, 4'b1001});
        tbl.push_back('{"sub_pos",    3'b001, 5'b00101, 5'b11100, 5'b01001, 4'b0000});
        tbl.push_back('{"sub_neg",    3'b001, 5'b11100, 5'b00101, 5'b10111, 4'b1010});
        tbl.push_back('{"sub_xx",     3'b001, 5'b11111, 5'b11111, 5'b00000, 4'b0110});
        tbl.push_back('{"rsb",        3'b010, 5'b00100, 5'b00011, 5'b11111, 4'b1000});
        tbl.push_back('{"bic",        3'b011, 5'b00100, 5'b00011, 5'b00100, 4'b0000});
        tbl.push_back('{"and",        3'b100, 5'b00100, 5'b00101, 5'b00100, 4'b0000});
        tbl.push_back('{"orr",        3'b101, 5'b00100, 5'b00101, 5'b00101, 4'b0000});
        tbl.push_back('{"eor_zero",   3'b110, 5'b11111, 5'b11111, 5'b00000, 4'b0100});
        tbl.push_back('{"xnor",       3'b111, 5'b00101, 5'b11100, 5'b00110, 4'b0000});
        tbl.push_back('{"sub_minneg", 3'b001, 5'b10000, 5'b00001, 5'b01111, 4'b0011});
        tbl.push_back('{"sub_x_x",    3'b001, 5'b01010, 5'b01010, 5'b00000, 4'b0110});
        tbl.push_back('{"add_zero",   3'b000, 5'b00000, 5'b00000, 5'b00000, 4'b0100});
        tbl.push_back('{"rsb_minneg", 3'b010, 5'b00001, 5'b10000, 5'b01111, 4'b0011});

        bus.InA = '0;
        bus.InB = '0;
        bus.ALU_Control = 3'b000;
        rst_n = 1'b0;
        #12;
        check("reset_state", bus.Result, bus.NZCV, 5'b00000, 4'b0000, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; C/V on logic ops depend on history when held
        foreach (tbl[i]) begin
`ifdef WBIT_ALU_FLAG_HOLD_EN
            tmask = (tbl[i].op >= 3'b011) ? 4'b1100 : 4'b1111;
`else
            tmask = 4'b1111;
`endif
            apply(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_r, tbl[i].exp_f, tmask);
        end

        // Logic op after an overflowing add: C/V held or cleared
        apply("hold_setup", 3'b000, 5'b01111, 5'b00001, 5'b10000, 4'b1001, 4'b1111);
`ifdef WBIT_ALU_FLAG_HOLD_EN
        apply("hold_and", 3'b100, 5'b00000, 5'b00000, 5'b00000, 4'b0101, 4'b1111);
`else
        apply("clear_and", 3'b100, 5'b00000, 5'b00000, 5'b00000, 4'b0100, 4'b1111);
`endif

        // Asynchronous reset mid-operation clears outputs before the next edge
        apply("pre_reset", 3'b000, 5'b01111, 5'b00001, 5'b10000, 4'b1001, 4'b1111);
        #2;
        rst_n = 1'b0;
        mc = 1'b0;
        mv = 1'b0;
        #1;
        check("async_reset", bus.Result, bus.NZCV, 5'b00000, 4'b0000, 4'b1111);
        @(posedge clk);
        #1;
        check("reset_held", bus.Result, bus.NZCV, 5'b00000, 4'b0000, 4'b1111);
        @(negedge clk);
        rst_n = 1'b1;
        apply("first_after_reset", 3'b001, 5'b11100, 5'b00101, 5'b10111, 4'b1010, 4'b1111);
`ifdef WBIT_ALU_FLAG_HOLD_EN
        apply("hold_after_sub", 3'b101, 5'b00000, 5'b00000, 5'b00000, 4'b0110, 4'b1111);
`endif

        // Random vectors against the reference model
        for (int i = 0; i < 400; i++) begin
            rop  = 3'($urandom_range(0, 7));
            ra   = W'($urandom);
            rb   = W'($urandom);
            mexp = model(rop, ra, rb, mc, mv);
            apply("random", rop, ra, rb, mexp[W+3:4], mexp[3:0], 4'b1111);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
